// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO controllers: Gray/binary pointer conversion.
// The functions work on a wide pointer type; callers zero-extend in and truncate out.
package fifo_pkg;

  localparam int unsigned PTR_W_MAX = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// Only one bit of the input changes at a time, so a per-bit synchroniser is safe.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // NOTE: sequential state uses non-blocking assignments so the second flop
  // samples the first flop's old value, giving two full stages.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer/flag controller of the asynchronous FIFO.
// Flags and count are registered from next-state values against the synchronised read pointer.
module async_fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SIZE       = $clog2(FIFO_DEPTH),
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            wr_req_i,
  input  logic [SIZE:0]   rd_addr_gray_i,
  output logic            wr_en_o,
  output logic [SIZE-1:0] wr_addr_o,
  output logic [SIZE:0]   wr_addr_gray_o,
  output logic            full_o,
  output logic            almost_full_o,
  output logic [SIZE:0]   wr_count_o,
  output logic            overflow_o
);

  localparam int unsigned PW = SIZE + 1;
  localparam logic [SIZE:0] AF_LEVEL = PW'(FIFO_DEPTH - AF_MARGIN);

  logic [SIZE:0] wr_bin_q,   wr_bin_d;
  logic [SIZE:0] wr_gray_q,  wr_gray_d;
  logic [SIZE:0] count_q,    count_d;
  logic          full_q,     full_d;
  logic          afull_q,    afull_d;
  logic          overflow_q, overflow_d;
  logic [SIZE:0] rd_sync2;
  logic [SIZE:0] rd_bin_sync;
  logic          accept;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rd_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (rd_addr_gray_i),
    .q_o     (rd_sync2)
  );

  assign accept = wr_req_i & ~full_q;

  // NOTE: every signal assigned in this block gets a value on every path
  // before any condition, so no latch can be inferred.
  always_comb begin
    wr_bin_d = wr_bin_q;
    if (accept) begin
      wr_bin_d = wr_bin_q + PW'(1);
    end
    wr_gray_d   = PW'(bin2gray(ptr_t'(wr_bin_d)));
    rd_bin_sync = PW'(gray2bin(ptr_t'(rd_sync2)));
    count_d     = wr_bin_d - rd_bin_sync;
    // Full when the write pointer is exactly one lap ahead: Gray form flips the top two bits.
    full_d      = (wr_gray_d == {~rd_sync2[SIZE:SIZE-1], rd_sync2[SIZE-2:0]});
    afull_d     = (count_d >= AF_LEVEL);
    overflow_d  = wr_req_i & full_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      count_q    <= count_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_en_o        = accept;
  assign wr_addr_o      = wr_bin_q[SIZE-1:0];
  assign wr_addr_gray_o = wr_gray_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign wr_count_o     = count_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed scenarios plus randomized traffic against
// an occupancy model built from total write/read counts and a two-edge read-pointer delay.
module tb_async_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       wr_req_i;
  logic [3:0] rd_addr_gray_i;
  logic       wr_en_o;
  logic [2:0] wr_addr_o;
  logic [3:0] wr_addr_gray_o;
  logic       full_o;
  logic       almost_full_o;
  logic [3:0] wr_count_o;
  logic       overflow_o;

  async_fifo_wr_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .AF_MARGIN  (AF)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .wr_req_i       (wr_req_i),
    .rd_addr_gray_i (rd_addr_gray_i),
    .wr_en_o        (wr_en_o),
    .wr_addr_o      (wr_addr_o),
    .wr_addr_gray_o (wr_addr_gray_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .wr_count_o     (wr_count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Model: total accepted writes, reader position, and reader positions seen at the last two edges.
  int   m_w, m_count, rd_ptr, m_rd_hist0, m_rd_hist1;
  logic m_full, m_af, m_ovf, m_wr_en;
  logic       obs_wr_en;
  logic [2:0] obs_addr;

  function automatic logic [3:0] to_gray(input int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_count = 0; rd_ptr = 0; m_rd_hist0 = 0; m_rd_hist1 = 0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; m_wr_en = 1'b0;
  endtask

  // One clock cycle: drive at negedge, observe combinational outputs, advance model at posedge.
  task automatic step(input logic req);
    @(negedge clk_i);
    wr_req_i       = req;
    rd_addr_gray_i = to_gray(rd_ptr);
    #1;
    obs_wr_en = wr_en_o;
    obs_addr  = wr_addr_o;
    m_wr_en   = req && !m_full;
    @(posedge clk_i);
    m_ovf = req && m_full;
    if (m_wr_en) m_w++;
    m_count    = m_w - m_rd_hist1;
    m_full     = (m_count == DEPTH);
    m_af       = (m_count >= DEPTH - AF);
    m_rd_hist1 = m_rd_hist0;
    m_rd_hist0 = rd_ptr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; wr_req_i = 1'b0; rd_addr_gray_i = '0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; wr_req_i = 1'b0; rd_addr_gray_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({wr_en_o, wr_addr_o, wr_addr_gray_o, full_o, almost_full_o, wr_count_o, overflow_o} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {wr_en_o, wr_addr_o, wr_addr_gray_o, full_o, almost_full_o, wr_count_o, overflow_o});
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1);
      checks++;
      if (obs_addr !== 3'(i) || obs_wr_en !== 1'b1) begin
        failures++;
        $display("FAIL fill_addr[%0d]: got addr=%0d en=%0b expected addr=%0d en=1", i, obs_addr, obs_wr_en, i);
      end
      checks++;
      if (full_o !== (i == DEPTH - 1)) begin
        failures++;
        $display("FAIL fill_full[%0d]: got %0b expected %0b", i, full_o, (i == DEPTH - 1));
      end
      checks++;
      if (almost_full_o !== (i >= DEPTH - AF - 1)) begin
        failures++;
        $display("FAIL fill_afull[%0d]: got %0b expected %0b", i, almost_full_o, (i >= DEPTH - AF - 1));
      end
      checks++;
      if (wr_count_o !== 4'(i + 1)) begin
        failures++;
        $display("FAIL fill_count[%0d]: got %0d expected %0d", i, wr_count_o, i + 1);
      end
    end
    checks++;
    if (wr_addr_gray_o !== 4'b1100) begin
      failures++;
      $display("FAIL fill_gray: got %b expected 1100", wr_addr_gray_o);
    end
  endtask

  task automatic test_overflow();
    step(1'b1);
    checks++;
    if (obs_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL ovf_wr_en: got %0b expected 0", obs_wr_en);
    end
    checks++;
    if (overflow_o !== 1'b1 || wr_addr_gray_o !== 4'b1100 || wr_addr_o !== 3'd0 || wr_count_o !== 4'd8) begin
      failures++;
      $display("FAIL ovf_pulse: got ovf=%0b gray=%b addr=%0d cnt=%0d expected 1 1100 0 8",
               overflow_o, wr_addr_gray_o, wr_addr_o, wr_count_o);
    end
    step(1'b0);
    checks++;
    if (overflow_o !== 1'b0 || full_o !== 1'b1) begin
      failures++;
      $display("FAIL ovf_clear: got ovf=%0b full=%0b expected 0 1", overflow_o, full_o);
    end
  endtask

  task automatic test_release();
    rd_ptr = 1;
    step(1'b0);
    checks++;
    if (full_o !== 1'b1) begin
      failures++;
      $display("FAIL release_k: got full=%0b expected 1", full_o);
    end
    step(1'b0);
    checks++;
    if (full_o !== 1'b1) begin
      failures++;
      $display("FAIL release_k1: got full=%0b expected 1", full_o);
    end
    step(1'b0);
    checks++;
    if (full_o !== 1'b0 || wr_count_o !== 4'd7 || almost_full_o !== 1'b1) begin
      failures++;
      $display("FAIL release_k2: got full=%0b cnt=%0d af=%0b expected 0 7 1",
               full_o, wr_count_o, almost_full_o);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev_gray;
    logic       saw_wrap;
    saw_wrap = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rd_ptr    = (m_w >= 2) ? m_w - 2 : 0;
      prev_gray = wr_addr_gray_o;
      step(1'b1);
      if (prev_gray == 4'b1000 && wr_addr_gray_o == 4'b0000) saw_wrap = 1'b1;
      checks++;
      if ($countones(prev_gray ^ wr_addr_gray_o) != 1 || wr_addr_gray_o !== to_gray(m_w)) begin
        failures++;
        $display("FAIL wrap_gray[%0d]: got %b (prev %b) expected %b", i, wr_addr_gray_o, prev_gray, to_gray(m_w));
      end
      checks++;
      if (full_o !== 1'b0 || obs_wr_en !== 1'b1 || wr_count_o !== 4'(m_count)) begin
        failures++;
        $display("FAIL wrap_flags[%0d]: got full=%0b en=%0b cnt=%0d expected 0 1 %0d",
                 i, full_o, obs_wr_en, wr_count_o, m_count);
      end
    end
    checks++;
    if (saw_wrap !== 1'b1 || wr_addr_o !== 3'd4) begin
      failures++;
      $display("FAIL wrap_seen: got wrap=%0b addr=%0d expected 1 4", saw_wrap, wr_addr_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (rd_ptr < m_w && ($urandom % 3) == 0) rd_ptr++;
      step(($urandom % 4) != 0);
      checks++;
      if (obs_wr_en !== m_wr_en) begin
        failures++;
        $display("FAIL rand_wr_en[%0d]: got %0b expected %0b", i, obs_wr_en, m_wr_en);
      end
      checks++;
      if (wr_addr_o !== 3'(m_w % DEPTH) || wr_addr_gray_o !== to_gray(m_w)) begin
        failures++;
        $display("FAIL rand_ptr[%0d]: got addr=%0d gray=%b expected %0d %b",
                 i, wr_addr_o, wr_addr_gray_o, m_w % DEPTH, to_gray(m_w));
      end
      checks++;
      if (wr_count_o !== 4'(m_count)) begin
        failures++;
        $display("FAIL rand_count[%0d]: got %0d expected %0d", i, wr_count_o, m_count);
      end
      checks++;
      if (full_o !== m_full || almost_full_o !== m_af || overflow_o !== m_ovf) begin
        failures++;
        $display("FAIL rand_flags[%0d]: got full=%0b af=%0b ovf=%0b expected %0b %0b %0b",
                 i, full_o, almost_full_o, overflow_o, m_full, m_af, m_ovf);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    repeat (5) step(1'b1);
    checks++;
    if (wr_count_o !== 4'd5) begin
      failures++;
      $display("FAIL mid_pre_count: got %0d expected 5", wr_count_o);
    end
    @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({wr_addr_o, wr_addr_gray_o, full_o, almost_full_o, wr_count_o, overflow_o} !== 14'd0
        || wr_en_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: got regs=%0h en=%0b expected 0 1",
               {wr_addr_o, wr_addr_gray_o, full_o, almost_full_o, wr_count_o, overflow_o}, wr_en_o);
    end
    @(negedge clk_i);
    wr_req_i = 1'b0;
    rst_n_i  = 1'b1;
    model_reset();
    step(1'b1);
    checks++;
    if (obs_addr !== 3'd0 || obs_wr_en !== 1'b1 || wr_addr_o !== 3'd1 || wr_count_o !== 4'd1) begin
      failures++;
      $display("FAIL mid_first_write: got addr=%0d en=%0b next=%0d cnt=%0d expected 0 1 1 1",
               obs_addr, obs_wr_en, wr_addr_o, wr_count_o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_wrap();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-domain pointer and flag controller for the asynchronous FIFO. Accepts write requests, advances the binary and Gray write pointers, synchronises the read-domain Gray pointer into the write clock, and produces registered full/almost-full flags plus a fill count. It sits between the FIFO producer and the dual-port RAM write port. It publishes its Gray pointer to the read-domain controller.

## Interface
- FIFO_DEPTH, 8, number of entries; power of two, ≥ 4
- SIZE, $clog2(FIFO_DEPTH), RAM address width; pointers are SIZE+1 bits
- AF_MARGIN, 2, almost_full asserts when free entries ≤ AF_MARGIN; range 1..FIFO_DEPTH-1

Ports:
- clk_i  in  1  write-domain clock
- rst_n_i  in  1  asynchronous active-low reset, deasserted synchronously to clk_i by the integrator
- wr_req_i  in  1  producer write request
- rd_addr_gray_i  in  SIZE+1  read pointer (Gray) from read domain, unsynchronised
- wr_en_o  out  1  RAM write enable
- wr_addr_o  out  SIZE  RAM write address
- wr_addr_gray_o  out  SIZE+1  registered Gray write pointer to read domain
- full_o  out  1  FIFO full, registered
- almost_full_o  out  1  free entries ≤ AF_MARGIN, registered
- wr_count_o  out  SIZE+1  occupancy as seen from the write side, registered
- overflow_o  out  1  one-cycle pulse: request made while full

## Operation
- Accept = wr_req_i & ~full_o; wr_en_o = accept (combinational); wr_addr_o = wr_bin[SIZE-1:0].
- On accept: wr_bin_next = wr_bin + 1 (mod 2^(SIZE+1)); wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1). Else both hold.
- wr_gray is a register driven directly to wr_addr_gray_o; never derived combinationally at the output, so only one bit changes per increment.
- rd_addr_gray_i passes through two flops (rd_sync1, rd_sync2); only rd_sync2 is used.
- full_next = (wr_gray_next == {~rd_sync2[SIZE:SIZE-1], rd_sync2[SIZE-2:0]}).
- rd_bin_sync = Gray-to-binary(rd_sync2); count_next = wr_bin_next − rd_bin_sync, SIZE+1 bits, modulo.
- almost_full_next = (count_next ≥ FIFO_DEPTH − AF_MARGIN).
- overflow_o registered = wr_req_i & full_o; pointers, count, flags unaffected by the rejected request.
- Flags are pessimistic: full/almost_full may stay asserted after the reader frees space, never deasserted early.

## Timing
- Reset (async, rst_n_i low): wr_bin, wr_gray, rd_sync1, rd_sync2 = 0; full_o = 0; almost_full_o = 0; wr_count_o = 0; overflow_o = 0; wr_en_o = 0 since full_o = 0 only if wr_req_i low (combinational follows wr_req_i).
- Write latency: accept at edge N → wr_addr_o, wr_addr_gray_o, wr_count_o, full_o, almost_full_o updated at edge N.
- Filling write: the FIFO_DEPTH-th unread accept raises full_o at that same edge; the next cycle's request is rejected.
- Release: read Gray change before edge K → rd_sync1 at K, rd_sync2 at K+1, full_o/almost_full_o/wr_count_o reflect it at K+2.
- Simultaneous accept and read-pointer change: both folded into the same next-state computation; no lost update.
- Wrap: wr_bin 2·FIFO_DEPTH−1 → 0; Gray changes only MSB; count arithmetic modulo 2^(SIZE+1).
- Reset mid-operation: all state returns to reset values immediately; read side must be reset together.

## Structure
- Shared package fifo_pkg: bin2gray and gray2bin functions (parameterised width), used also by the read controller.
- One sub-module: sync_2ff (parameter WIDTH, clk_i, rst_n_i, async reset to 0), instantiated for rd_addr_gray_i; reused by the read side.
- Full comparison implemented inline on next-state values (registered flag), not by instantiating the combinational comparator.

## Test plan
- DEPTH=8, read pointer held 0, 8 back-to-back requests → wr_addr_o 0..7, full_o high at 8th accept edge, wr_count_o=8, wr_addr_gray_o=4'b1100.
- Continue request while full → wr_en_o=0, overflow_o one-cycle pulse next edge, pointers unchanged.
- AF_MARGIN=2, writes from empty → almost_full_o rises at 6th accept (wr_count_o=6), full at 8th.
- Full FIFO, drive rd_addr_gray_i 0→0001 → full_o falls exactly 2 edges after first capture edge; wr_count_o=7.
- 20 writes with reader tracking → wr_bin wraps 15→0, wr_addr_gray_o steps 1000→0000, single-bit change every increment, no false full.
- Assert rst_n_i mid-burst at count 5 → all outputs 0 asynchronously; after release, first write goes to address 0.
